// File: rtl/keypad_scan_pkg.sv
// rtl/keypad_scan_pkg.sv - shared state encoding, key map and column helpers for the keypad scanner
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Nibble {r,c} holds the legend printed on the Pmod KYPD key at row r, column c.
  localparam logic [63:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [5:0] idx;
    idx = {r, c, 2'b00};
    return KEYMAP[idx +: 4];
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix lines plus the decoded key outputs
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_tick_gen.sv
// rtl/keypad_scan_tick_gen.sv - free-running prescaler, one tick every 2**N clocks
module scan_tick_gen #(
  parameter int N = 18
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [N-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else        r_cnt <= r_cnt + {{(N-1){1'b0}}, 1'b1};
  end

  assign tick = &r_cnt;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with press/release debounce and hex decode
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int N        = 18,
  parameter int DB_TICKS = 3
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam logic [3:0] DB_T = 4'(DB_TICKS);

  logic       w_tick;
  logic [3:0] r_row_s1, r_row_s2;
  state_t     r_state, w_state_next;
  logic [1:0] r_col_idx;
  logic [3:0] r_row_lat;
  logic [3:0] r_cnt, w_cnt_next;
  logic [3:0] r_key_code;
  logic       r_key_valid, r_key_held;

  logic [3:0] w_hot;
  logic       w_hot_valid;
  logic [3:0] w_cnt_inc;
  logic       w_latch, w_accept, w_advance;
  logic [3:0] w_code_row;

  scan_tick_gen #(.N(N)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= kp.row;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_hot       = ~r_row_s2;
  assign w_hot_valid = is_onehot(w_hot);
  assign w_cnt_inc   = r_cnt + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= SCAN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      case (r_state)
        SCAN:     if (w_hot_valid) w_state_next = (DB_T == 4'd1) ? HELD : DEBOUNCE;
        DEBOUNCE: if (w_hot != r_row_lat)  w_state_next = SCAN;
                  else if (w_cnt_inc >= DB_T) w_state_next = HELD;
        HELD:     if (w_hot == 4'd0 && w_cnt_inc >= DB_T) w_state_next = SCAN;
        default:  w_state_next = SCAN;
      endcase
    end
  end

  // In HELD the count measures consecutive idle ticks; any low row restarts it.
  always_comb begin
    w_latch    = 1'b0;
    w_accept   = 1'b0;
    w_advance  = 1'b0;
    w_cnt_next = r_cnt;
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_hot_valid) begin
            w_latch = 1'b1;
            if (DB_T == 4'd1) begin
              w_accept   = 1'b1;
              w_cnt_next = 4'd0;
            end else begin
              w_cnt_next = 4'd1;
            end
          end else begin
            w_advance = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (w_hot != r_row_lat) begin
            w_advance  = 1'b1;
            w_cnt_next = 4'd0;
          end else if (w_cnt_inc >= DB_T) begin
            w_accept   = 1'b1;
            w_cnt_next = 4'd0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        HELD: begin
          if (w_hot != 4'd0) begin
            w_cnt_next = 4'd0;
          end else if (w_cnt_inc >= DB_T) begin
            w_advance  = 1'b1;
            w_cnt_next = 4'd0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        default: w_cnt_next = 4'd0;
      endcase
    end
  end

  assign w_code_row = w_latch ? w_hot : r_row_lat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col_idx   <= 2'd0;
      r_row_lat   <= 4'd0;
      r_cnt       <= 4'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_key_valid <= w_accept;
      r_key_held  <= (w_state_next == HELD);
      if (w_advance) r_col_idx <= r_col_idx + 2'd1;
      if (w_latch)   r_row_lat <= w_hot;
      if (w_accept)  r_key_code <= key_lookup(onehot_idx(w_code_row), r_col_idx);
    end
  end

  assign kp.col       = col_drive(r_col_idx);
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed checks of keypad_scan against a switch-matrix model (N=2, DB_TICKS=2)
module tb_keypad_scan;

  typedef struct {
    logic [15:0] mask;
    int          hold;
    int          rel;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pressed = 16'h0;
  logic [3:0]  w_row;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [3:0]  last_code = 4'h0;
  vec_t        vecs [16];
  logic [3:0]  sweep_codes [16];

  keypad_scan_if kif ();

  keypad_scan #(.N(2), .DB_TICKS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.master)
  );

  always #5 clk = ~clk;

  // Pressed switch at (r,c) shorts row r to column c, so a row goes low only while its column is driven.
  always_comb begin
    w_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col[c]) w_row[r] = 1'b0;
  end
  assign kif.row = w_row;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n * 4; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        pulses++;
        last_code = kif.key_code;
      end
    end
  endtask

  function automatic logic [3:0] exp_col(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (c % 4));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic got;
    sweep_codes = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                    4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    for (int i = 0; i < 16; i++) begin
      vecs[i].mask       = 16'h0001 << i;
      vecs[i].hold       = 8;
      vecs[i].rel        = 4;
      vecs[i].exp_pulses = 1;
      vecs[i].exp_code   = sweep_codes[i];
      vecs[i].exp_held   = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("reset_col", 32'(kif.col), 32'hE);
    check("reset_valid", 32'(kif.key_valid), 32'h0);
    check("reset_held", 32'(kif.key_held), 32'h0);
    check("reset_code", 32'(kif.key_code), 32'h0);
    reset = 1'b1;

    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("col_step_%0d", k), 32'(kif.col), 32'(exp_col(k / 4)));
    end

    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midscan_reset_col", 32'(kif.col), 32'hE);
    check("midscan_reset_valid", 32'(kif.key_valid), 32'h0);
    check("midscan_reset_held", 32'(kif.key_held), 32'h0);
    check("midscan_reset_code", 32'(kif.key_code), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    pressed = 16'h0001 << 6;
    pulses = 0;
    run_ticks(20);
    check("key6_pulses", 32'(pulses), 32'd1);
    check("key6_code", 32'(last_code), 32'h6);
    check("key6_held", 32'(kif.key_held), 32'h1);
    check("key6_col_frozen", 32'(kif.col), 32'hB);

    pressed = 16'h0;
    pulses = 0;
    run_ticks(1);
    check("bounce_rel1_held", 32'(kif.key_held), 32'h1);
    pressed = 16'h0001 << 6;
    run_ticks(1);
    check("bounce_press_held", 32'(kif.key_held), 32'h1);
    pressed = 16'h0;
    run_ticks(1);
    check("bounce_rel_a_held", 32'(kif.key_held), 32'h1);
    run_ticks(1);
    check("bounce_rel_b_held", 32'(kif.key_held), 32'h0);
    check("bounce_resume_col", 32'(kif.col), 32'h7);
    check("bounce_pulses", 32'(pulses), 32'd0);

    run_ticks(1);
    pressed = 16'h0001 << 12;
    pulses = 0;
    run_ticks(1);
    pressed = 16'h0;
    run_ticks(1);
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_held", 32'(kif.key_held), 32'h0);
    check("glitch_col", 32'(kif.col), 32'hD);
    check("glitch_code_kept", 32'(kif.key_code), 32'h6);

    pressed = (16'h0001 << 1) | (16'h0001 << 9);
    pulses = 0;
    run_ticks(8);
    check("multihot_pulses", 32'(pulses), 32'd0);
    check("multihot_held", 32'(kif.key_held), 32'h0);
    pressed = 16'h0001 << 3;
    run_ticks(8);
    pressed = 16'h0;
    run_ticks(4);
    check("after_multihot_pulses", 32'(pulses), 32'd1);
    check("after_multihot_code", 32'(last_code), 32'hA);

    for (int i = 0; i < 16; i++) begin
      pressed = vecs[i].mask;
      pulses = 0;
      run_ticks(vecs[i].hold);
      check($sformatf("sweep%0d_held_pressed", i), 32'(kif.key_held), 32'h1);
      pressed = 16'h0;
      run_ticks(vecs[i].rel);
      check($sformatf("sweep%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
      check($sformatf("sweep%0d_code", i), 32'(last_code), 32'(vecs[i].exp_code));
      check($sformatf("sweep%0d_held_released", i), 32'(kif.key_held), 32'(vecs[i].exp_held));
    end

    pressed = 16'h0001 << 5;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) got = 1'b1;
    end
    check("valid_before_reset_seen", 32'(got), 32'h1);
    reset = 1'b0;
    #1;
    check("reset_kills_valid", 32'(kif.key_valid), 32'h0);
    check("reset_kills_code", 32'(kif.key_code), 32'h0);
    check("reset_kills_held", 32'(kif.key_held), 32'h0);
    check("reset_kills_col", 32'(kif.col), 32'hE);
    pressed = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    run_ticks(8);
    check("no_pending_pulses", 32'(pulses), 32'd0);
    check("no_pending_code", 32'(kif.key_code), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scan-side reader for a 4x4 matrix hex keypad (Pmod KYPD style). It is the input counterpart of the time-multiplexed seven-segment display path.
- Drives one column low at a time and samples the rows, using the same prescaled-scan scheme the display mux uses.
- Debounces presses and releases. Emits a 4-bit hex key code with a one-cycle valid strobe.
- Feeds operand/exponent entry for the FP adder demo in place of slide switches.

Parameters:
- N, 18, prescaler width; one scan tick every 2**N clk cycles.
- DB_TICKS, 3, consecutive stable ticks required to accept a press or a release (range 1..15).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col  output  4  keypad columns, active-low, exactly one bit low at any time
- key_code  output  4  hex value of the last accepted key
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_held  output  1  high while the accepted key is still pressed

Behaviour:
- Reset (reset=0, async):
  - col=4'b1110, key_code=4'h0, key_valid=0, key_held=0.
  - Prescaler=0, debounce count=0, state=SCAN, both row synchroniser stages=4'b1111.
- Row synchroniser:
  - Two flip-flops on row; all decisions use the second stage (row_s).
- Tick:
  - Free-running N-bit counter; tick=1 for one cycle when the counter equals all-ones, then it wraps to 0.
  - All FSM actions below occur only on tick cycles, except the key_valid deassert.
- Column index c (0..3): col = ~(4'b0001 << c).
- Row pattern r_hot = ~row_s. A pattern is valid only if exactly one bit is set.
- SCAN:
  - r_hot valid -> latch r and c, debounce count=1, go to DEBOUNCE; c is frozen.
  - r_hot zero or multi-hot -> c=c+1 mod 4 (3 wraps to 0).
- DEBOUNCE:
  - r_hot equals the latched one-hot -> count+1.
  - Anything else -> SCAN; c advances.
  - count reaches DB_TICKS -> key_code=map(r,c), key_valid=1 for exactly one clk cycle, key_held=1, go to HELD.
  - DB_TICKS=1 accepts on the first sampling tick, with no extra tick.
- HELD:
  - c stays frozen; count tracks consecutive ticks with r_hot zero.
  - Any row low resets the count to 0.
  - count reaches DB_TICKS -> key_held=0, go to SCAN, c advances.
  - A second key pressed in another column during HELD is ignored.
  - A second key in the same column (multi-hot) counts as still held.
- Key map (row0..3 by col0..3), key_code unchanged until the next accepted key:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Latency: press stable on row_s at the tick when its column is active -> key_valid rises DB_TICKS-1 ticks later, plus 1 clk (registered output).
- Reset mid-operation: immediate return to reset values, including an asserted key_valid. No pending key is reported after reset deasserts.

Decomposition:
- Shared include/package:
  - State encoding localparams: SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2.
  - KEYMAP 16x4 constant indexed {r,c}.
  - Column-drive encoding function.
- Sub-module scan_tick_gen (parameter N, ports clk, reset, tick): the prescaler, reusable by the display mux refresh.
- Synchroniser and FSM stay in keypad_scan.

Test Plan (N=2, DB_TICKS=2; tick every 4 clk):
- Reset asserted mid-scan -> col=1110, key_valid=0, key_held=0, key_code=0 on the same cycle. After release, col steps 1110->1101->1011->0111->1110 every 4 clk.
- Model drives row[1]=0 while col[2]=0, held 20 ticks -> exactly one key_valid pulse with key_code=4'h6. key_held stays 1; col frozen at 1011.
- Release, then hold 1 tick bounce -> no new key_valid; key_held drops only after 2 consecutive all-high ticks. Then scanning resumes with col=0111.
- Press row3/col0 for one tick only (glitch) -> no key_valid; scanning continues.
- Rows 0 and 2 low together in col1 during SCAN -> ignored, no key_valid. Pressing only row0/col3 afterwards -> key_code=4'hA.
- Sweep all 16 keys via the matrix model -> codes 1,2,3,A,4,5,6,B,7,8,9,C,0,F,E,D in order, with one pulse each.
